// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared pointer type, flag helpers and default depth for the feeder FIFO.
package sync_fifo_pkg;
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_ADDR_W = $clog2(DEFAULT_DEPTH);
    typedef logic [DEFAULT_ADDR_W:0] ptr_t;
    // Pointers are passed zero-extended so the helpers serve any DEPTH; aw is the index width.
    function automatic logic is_full(input logic [31:0] wr_ptr, input logic [31:0] rd_ptr, input int unsigned aw);
        return (wr_ptr ^ rd_ptr) == (32'd1 << aw);
    endfunction
    function automatic logic is_empty(input logic [31:0] wr_ptr, input logic [31:0] rd_ptr);
        return wr_ptr == rd_ptr;
    endfunction
endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: DEPTH x N register array, one synchronous write port, one combinational read port, no reset.
module fifo_mem_2p #(
    parameter int N = 2,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [N-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [N-1:0]  rdata_o
);
    logic [N-1:0] mem_q [DEPTH];
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_feeder.sv
// sync_fifo_feeder: FWFT FIFO with valid/ready read side and fill level.
// Define SYNC_FIFO_FEEDER_ERR_FLAG_EN to add sticky ovf_err/udf_err outputs.
module sync_fifo_feeder
    import sync_fifo_pkg::*;
#(
    parameter int N = 2,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic            Clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [N-1:0]    wr_data,
    output logic            full,
    input  logic            rd_rdy,
    output logic            rd_vld,
    output logic [N-1:0]    rd_data,
    output logic            empty,
    output logic [ADDR_W:0] level
`ifdef SYNC_FIFO_FEEDER_ERR_FLAG_EN
    ,
    output logic            ovf_err,
    output logic            udf_err
`endif
);
    localparam logic [ADDR_W:0] PTR_ONE = 1;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
    logic            full_q, full_d, empty_q, empty_d, wr_acc, rd_acc;
    logic [N-1:0]    rd_data_q, rd_data_d, mem_rdata;
    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = ~empty_q & rd_rdy;
    fifo_mem_2p #(.N(N), .DEPTH(DEPTH)) u_mem (
        .clk_i   (Clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_d[ADDR_W-1:0]),
        .rdata_o (mem_rdata)
    );
    // The head word is registered from the next-state read pointer; a word
    // written into the slot that becomes the head this cycle is forwarded.
    always_comb begin
        wr_ptr_d  = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d   = (wr_acc & ~rd_acc) ? level_q + PTR_ONE :
                    (rd_acc & ~wr_acc) ? level_q - PTR_ONE : level_q;
        full_d    = is_full(32'(wr_ptr_d), 32'(rd_ptr_d), ADDR_W);
        empty_d   = is_empty(32'(wr_ptr_d), 32'(rd_ptr_d));
        rd_data_d = empty_d ? rd_data_q :
                    (wr_acc && wr_ptr_q[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) ? wr_data : mem_rdata;
    end
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            rd_data_q <= rd_data_d;
        end
    end
    assign full    = full_q;
    assign empty   = empty_q;
    assign rd_vld  = ~empty_q;
    assign rd_data = rd_data_q;
    assign level   = level_q;
`ifdef SYNC_FIFO_FEEDER_ERR_FLAG_EN
    logic ovf_q, udf_q;
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (wr_en & full_q);
            udf_q <= udf_q | (rd_rdy & empty_q);
        end
    end
    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`endif
endmodule

// File: tb/tb_sync_fifo_feeder.sv
// tb_sync_fifo_feeder: vector table, corner sequences and randomized queue-model check.
module tb_sync_fifo_feeder;
    localparam int N = 2;
    localparam int DEPTH = 4;
    logic Clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, rd_rdy = 1'b0;
    logic [N-1:0] wr_data = '0;
    logic full, rd_vld, empty;
    logic [N-1:0] rd_data;
    logic [2:0] level;
`ifdef SYNC_FIFO_FEEDER_ERR_FLAG_EN
    logic ovf_err, udf_err;
`endif
    int vectors = 0, errors = 0;
    always #5 Clk = ~Clk;
    sync_fifo_feeder #(.N(N), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .rd_rdy(rd_rdy), .rd_vld(rd_vld), .rd_data(rd_data), .empty(empty), .level(level)
`ifdef SYNC_FIFO_FEEDER_ERR_FLAG_EN
        , .ovf_err(ovf_err), .udf_err(udf_err)
`endif
    );
    typedef struct {
        logic rst_n, wr_en, rd_rdy;
        logic [1:0] wr_data;
        logic vld, chk_data, full;
        logic [1:0] data;
        logic [2:0] level;
    } vec_t;
    vec_t tv[$];
    function automatic vec_t mk(input logic r, input logic w, input logic [1:0] d, input logic rr,
                                input logic vl, input logic cd, input logic [1:0] od, input logic [2:0] lv, input logic fl);
        vec_t v;
        v.rst_n = r; v.wr_en = w; v.wr_data = d; v.rd_rdy = rr;
        v.vld = vl; v.chk_data = cd; v.data = od; v.level = lv; v.full = fl;
        return v;
    endfunction
    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic step();
        @(posedge Clk);
        #1;
    endtask
    int q[$];
    initial begin
        // reset, fill, overfill, drain
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        tv.push_back(mk(1, 1, 1, 0, 1, 1, 1, 1, 0));
        tv.push_back(mk(1, 1, 2, 0, 1, 1, 1, 2, 0));
        tv.push_back(mk(1, 1, 3, 0, 1, 1, 1, 3, 0));
        tv.push_back(mk(1, 1, 0, 0, 1, 1, 1, 4, 1));
        tv.push_back(mk(1, 1, 2, 0, 1, 1, 1, 4, 1));
        tv.push_back(mk(1, 0, 0, 1, 1, 1, 2, 3, 0));
        tv.push_back(mk(1, 0, 0, 1, 1, 1, 3, 2, 0));
        tv.push_back(mk(1, 0, 0, 1, 1, 1, 0, 1, 0));
        tv.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
        // refill, then write+read at full (write dropped), then drain
        tv.push_back(mk(1, 1, 1, 0, 1, 1, 1, 1, 0));
        tv.push_back(mk(1, 1, 2, 0, 1, 1, 1, 2, 0));
        tv.push_back(mk(1, 1, 3, 0, 1, 1, 1, 3, 0));
        tv.push_back(mk(1, 1, 0, 0, 1, 1, 1, 4, 1));
        tv.push_back(mk(1, 1, 3, 1, 1, 1, 2, 3, 0));
        tv.push_back(mk(1, 1, 3, 0, 1, 1, 2, 4, 1));
        tv.push_back(mk(1, 0, 0, 1, 1, 1, 3, 3, 0));
        tv.push_back(mk(1, 0, 0, 1, 1, 1, 0, 2, 0));
        tv.push_back(mk(1, 0, 0, 1, 1, 1, 3, 1, 0));
        tv.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
        step();
        chk("init_empty", int'(empty), 1);
        chk("init_level", int'(level), 0);
        chk("init_vld", int'(rd_vld), 0);
        for (int i = 0; i < tv.size(); i++) begin
            rst_n = tv[i].rst_n; wr_en = tv[i].wr_en; wr_data = tv[i].wr_data; rd_rdy = tv[i].rd_rdy;
            step();
            chk($sformatf("v%0d_vld", i), int'(rd_vld), int'(tv[i].vld));
            chk($sformatf("v%0d_empty", i), int'(empty), int'(!tv[i].vld));
            chk($sformatf("v%0d_level", i), int'(level), int'(tv[i].level));
            chk($sformatf("v%0d_full", i), int'(full), int'(tv[i].full));
            if (tv[i].chk_data) chk($sformatf("v%0d_data", i), int'(rd_data), int'(tv[i].data));
        end
`ifdef SYNC_FIFO_FEEDER_ERR_FLAG_EN
        chk("ovf_err_set", int'(ovf_err), 1);
        chk("udf_err_set", int'(udf_err), 1);
`endif
        // wrap-around stream
        for (int i = 0; i < 12; i++) begin
            wr_en = 1; wr_data = 2'(i % 4); rd_rdy = 1;
            step();
            chk($sformatf("wrap%0d_data", i), int'(rd_data), i % 4);
            chk($sformatf("wrap%0d_level", i), int'(level), 1);
            chk($sformatf("wrap%0d_full", i), int'(full), 0);
            chk($sformatf("wrap%0d_vld", i), int'(rd_vld), 1);
        end
        wr_en = 0;
        step();
        chk("wrap_end_empty", int'(empty), 1);
        // mid-burst reset
        rd_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1; wr_data = 2'(i + 1);
            step();
        end
        wr_en = 0;
        chk("pre_rst_level", int'(level), 3);
        rst_n = 0;
        #1;
        chk("rst_async_vld", int'(rd_vld), 0);
        chk("rst_async_level", int'(level), 0);
        chk("rst_async_empty", int'(empty), 1);
`ifdef SYNC_FIFO_FEEDER_ERR_FLAG_EN
        chk("rst_ovf_clr", int'(ovf_err), 0);
        chk("rst_udf_clr", int'(udf_err), 0);
`endif
        step();
        rst_n = 1;
        wr_en = 1; wr_data = 2;
        step();
        wr_en = 0;
        chk("post_rst_vld", int'(rd_vld), 1);
        chk("post_rst_data", int'(rd_data), 2);
        chk("post_rst_level", int'(level), 1);
        // randomized traffic against a queue model
        q = {2};
        for (int c = 0; c < 400; c++) begin
            bit wa, ra;
            wr_en = 1'($urandom_range(0, 1));
            wr_data = 2'($urandom_range(0, 3));
            rd_rdy = ($urandom_range(0, 9) < 6);
            wa = wr_en && q.size() < DEPTH;
            ra = rd_rdy && q.size() > 0;
            if (ra) void'(q.pop_front());
            if (wa) q.push_back(int'(wr_data));
            step();
            chk("rnd_level", int'(level), q.size());
            chk("rnd_full", int'(full), int'(q.size() == DEPTH));
            chk("rnd_vld", int'(rd_vld), int'(q.size() > 0));
            if (q.size() > 0) chk("rnd_data", int'(rd_data), q[0]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/sync_fifo_feeder.md
Name: sync_fifo_feeder

Overview:
- Synchronous first-word-fall-through FIFO that sits directly upstream of the N-bit processing stage.
- It buffers bursty N-bit words from a producer.
- It presents one word per cycle to the consumer stage through a valid/ready pair; valid maps onto the consumer's `ena`, data onto its `Din`.
- It decouples producer rate from consumer stalls and keeps a fill level for flow control.

Parameters:
- N, 2, data word width in bits; matches the consumer's `Din` width.
- DEPTH, 4, number of storage entries; must be a power of 2 and at least 2.
- ADDR_W, $clog2(DEPTH), pointer index width; derived, never overridden.

Ports:
- Clk  input  1  single system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset; assertion is immediate, release is synchronous to Clk.
- wr_en  input  1  producer write strobe.
- wr_data  input  N  producer data word.
- full  output  1  no free entry; registered.
- rd_rdy  input  1  consumer accepts the head word this cycle.
- rd_vld  output  1  head word valid; drives the consumer's `ena`.
- rd_data  output  N  head word; drives the consumer's `Din`.
- empty  output  1  no stored entry; registered. Equals ~rd_vld.
- level  output  ADDR_W+1  number of stored entries, 0..DEPTH.

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr=0, rd_ptr=0, level=0.
  - full=0, empty=1, rd_vld=0, rd_data=0.
  - Storage array is not reset.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W+1 bits; the MSB is the wrap bit.
  - full when indices are equal and wrap bits differ.
  - empty when both pointers are equal.
  - Pointers wrap naturally from DEPTH-1 to 0 with the wrap bit toggling.
- Write accepted (wr_acc) = wr_en & ~full. The entry is stored at mem[wr_ptr] on that edge and wr_ptr increments.
- Read accepted (rd_acc) = rd_vld & rd_rdy. rd_ptr increments on that edge.
- Latency:
  - A word written into an empty FIFO appears on rd_data with rd_vld=1 exactly one cycle after the write edge.
  - There is no bypass in the same cycle.
- FWFT: rd_data always shows mem[rd_ptr] while rd_vld=1. It is held stable while rd_vld=1 & rd_rdy=0.
- rd_data value when rd_vld=0 is don't-care; the implementation keeps the last value.
- level update:
  - level+1 on wr_acc only.
  - level-1 on rd_acc only.
  - Unchanged when both occur or neither occurs.
- full and empty are recomputed from next-state pointers, so they are valid in the cycle after any accept.
- Boundary conditions:
  - Full with wr_en=1 and rd_acc=1: the write is dropped because full is registered. Level goes from DEPTH to DEPTH-1 and full deasserts next cycle.
  - Full with wr_en=1 and no read: the write is dropped and the state is unchanged.
  - Empty with rd_rdy=1: no effect, because rd_vld=0.
  - Empty with wr_en=1: the write is accepted, and rd_vld=1 next cycle.
  - Simultaneous write and read at 0<level<DEPTH: both are accepted and level is unchanged.
- Reset mid-operation: all stored words are discarded immediately. rd_vld drops asynchronously, and the first post-reset write behaves as a write into an empty FIFO.

Optional Feature:
- Macro: SYNC_FIFO_FEEDER_ERR_FLAG_EN.
- Enabled:
  - Adds output ports ovf_err (1) and udf_err (1), both reset to 0.
  - ovf_err sets sticky on wr_en & full.
  - udf_err sets sticky on rd_rdy & empty.
  - Both clear only on reset.
- Disabled:
  - Ports and logic are absent.
  - Dropped writes and empty-read attempts are silent.
  - The core behaviour is otherwise identical.

Decomposition:
- Package sync_fifo_pkg holds:
  - ptr_t, a typedef of ADDR_W+1 bits.
  - Function is_full(wr_ptr, rd_ptr).
  - Function is_empty(wr_ptr, rd_ptr).
  - Constant DEFAULT_DEPTH=4.
- One sub-module, fifo_mem_2p: a DEPTH×N register array with one write port and one combinational read port, no reset. Pointer, flag and level logic stay in the top module.

Test Plan:
- Reset and first write:
  - Stimulus: hold rst_n=0 for 1 cycle, release, then write 2'd1.
  - Required response: empty=1, level=0 and rd_vld=0 throughout reset; one cycle after the write edge, rd_vld=1, rd_data=1, level=1.
- Fill to full then overfill:
  - Stimulus: with rd_rdy=0, write 1,2,3,0, then write 2 again.
  - Required response: full=1 and level=4 after the fourth write; the fifth write is dropped (level stays 4); ovf_err=1 when the macro is on.
- Drain in order:
  - Stimulus: from full (1,2,3,0), hold rd_rdy=1 for 5 cycles.
  - Required response: rd_data sequence 1,2,3,0; then empty=1 and rd_vld=0; udf_err=1 on the fifth cycle when the macro is on.
- Simultaneous read and write at full:
  - Stimulus: at level=4, wr_en=1 with data 3 and rd_rdy=1.
  - Required response: the write is dropped; level=3 and full=0 next cycle; the next write of 3 is accepted and level returns to 4.
- Wrap-around stream:
  - Stimulus: 12 back-to-back writes 0,1,2,3,… with rd_rdy=1 continuously.
  - Required response: output order matches input modulo 4; level stays at 1; full is never asserted; pointers wrap twice without data loss.
- Mid-burst reset:
  - Stimulus: at level=3, pulse rst_n=0 for 1 period, then write 2.
  - Required response: rd_vld falls immediately on reset; after release, rd_vld=1 and rd_data=2 one cycle after the write.
